// File: rtl/wb_dma_qctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_dma_qctrl
// Description : Q-Channel power controller sitting upstream of the DMA
//               Q-Channel wrapper. Watches bus/DMA activity, requests
//               quiescence after a programmable idle period, re-wakes the
//               DMA on new activity, gates the DMA clock enable and tells
//               the fabric when the DMA may accept traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_dma_qctrl #(
  parameter int ACT_W       = 4,
  parameter int CNT_W       = 8,
  parameter int IDLE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ACT_W-1:0] act_i,
  input  logic             lp_en_i,
  input  logic             qacceptn_i,
  input  logic             qdeny_i,
  output logic             qreqn_o,
  output logic             clk_en_o,
  output logic             ready_o,
  output logic             deny_o,
  output logic             err_o
);

  typedef enum logic [2:0] {
    ST_STOPPED  = 3'd0,
    ST_WAKE     = 3'd1,
    ST_EXIT     = 3'd2,
    ST_RUN      = 3'd3,
    ST_REQ      = 3'd4,
    ST_DENIED   = 3'd5,
    ST_CONTINUE = 3'd6
  } state_t;

  // Count value seen on the last idle cycle before the request is issued.
  localparam logic [CNT_W-1:0] C_IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               wake_pend_q, wake_pend_d;
  logic               err_q, err_d;
  logic               qacc_prev_q;
  logic               qdeny_prev_q;

  logic               w_act;
  logic               w_wake;
  logic               w_qacc_rise;
  logic               w_qacc_fall;
  logic               w_qdeny_rise;

  assign w_act        = |act_i;
  assign w_wake       = w_act | ~lp_en_i;
  assign w_qacc_rise  = qacceptn_i & ~qacc_prev_q;
  assign w_qacc_fall  = ~qacceptn_i & qacc_prev_q;
  assign w_qdeny_rise = qdeny_i & ~qdeny_prev_q;

  // Next-state, idle counter, pending-wake and sticky-error computation.
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = '0;
    wake_pend_d = wake_pend_q;
    err_d       = err_q;
    case (state_q)
      ST_STOPPED: begin
        if (w_qdeny_rise || w_qacc_rise) err_d = 1'b1;
        if (w_wake || wake_pend_q) begin
          state_d     = ST_WAKE;
          wake_pend_d = 1'b0;
        end
      end
      ST_WAKE: begin
        // Clock runs for one cycle before qreqn is raised.
        state_d = ST_EXIT;
      end
      ST_EXIT: begin
        if (w_qacc_fall || w_qdeny_rise) err_d = 1'b1;
        if (qacceptn_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_qacc_fall || w_qdeny_rise) err_d = 1'b1;
        if (w_wake) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == C_IDLE_LAST) begin
          state_d = ST_REQ;
        end else if (idle_cnt_q != {CNT_W{1'b1}}) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q;
        end
      end
      ST_REQ: begin
        // qreqn stays low until the handshake resolves; activity is remembered.
        if (w_act) wake_pend_d = 1'b1;
        if (!qacceptn_i && qdeny_i) begin
          err_d   = 1'b1;
          state_d = ST_STOPPED;
        end else if (!qacceptn_i) begin
          state_d = ST_STOPPED;
        end else if (qdeny_i) begin
          state_d = ST_DENIED;
        end
      end
      ST_DENIED: begin
        state_d = ST_CONTINUE;
      end
      ST_CONTINUE: begin
        if (w_qacc_fall) err_d = 1'b1;
        if (!qdeny_i) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_STOPPED;
      end
    endcase
  end

  // State and edge-detect registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_STOPPED;
      idle_cnt_q   <= '0;
      wake_pend_q  <= 1'b0;
      err_q        <= 1'b0;
      qacc_prev_q  <= 1'b0;
      qdeny_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      wake_pend_q  <= wake_pend_d;
      err_q        <= err_d;
      qacc_prev_q  <= qacceptn_i;
      qdeny_prev_q <= qdeny_i;
    end
  end

  // Outputs decode from registered state only.
  assign qreqn_o  = (state_q == ST_EXIT) || (state_q == ST_RUN) ||
                    (state_q == ST_CONTINUE);
  assign clk_en_o = (state_q != ST_STOPPED);
  assign ready_o  = (state_q == ST_RUN);
  assign deny_o   = (state_q == ST_DENIED);
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_qctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_dma_qctrl
// Description : Scoreboard bench for wb_dma_qctrl. Stimulus pushes expected
//               output vectors {qreqn,clk_en,ready,deny,err} with the cycle
//               they must appear in; a monitor pops one entry per output
//               change and checks both value and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dma_qctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] act;
  logic       lp_en;
  logic       qacc;
  logic       qdeny;
  logic       qreqn, clk_en, ready, deny, err;

  typedef struct {
    int         cyc;
    logic [4:0] vec;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic done   = 1'b0;

  wb_dma_qctrl #(.ACT_W(4), .CNT_W(8), .IDLE_CYCLES(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .act_i      (act),
    .lp_en_i    (lp_en),
    .qacceptn_i (qacc),
    .qdeny_i    (qdeny),
    .qreqn_o    (qreqn),
    .clk_en_o   (clk_en),
    .ready_o    (ready),
    .deny_o     (deny),
    .err_o      (err)
  );

  // Free-running clock and posedge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect vector v to appear dc edges from now (dc < 0 -> any cycle).
  task automatic expect_at(input int dc, input logic [4:0] v, input string name);
    exp_t e;
    e.cyc  = (dc < 0) ? -1 : cyc + dc;
    e.vec  = v;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: one scoreboard entry is consumed per output change.
  logic [4:0] prev_v;
  logic       first = 1'b1;
  always @(negedge clk) begin
    logic [4:0] v;
    exp_t       e;
    v = {qreqn, clk_en, ready, deny, err};
    if (mon_en && !done) begin
      if (first || v !== prev_v) begin
        n_cmp = n_cmp + 1;
        if (q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_change: got %b at cycle %0d, required unchanged %b",
                   v, cyc, prev_v);
        end else begin
          e = q.pop_front();
          if (v !== e.vec || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                     e.name, v, cyc, e.vec, e.cyc);
          end
        end
        first = 1'b0;
      end
      prev_v = v;
    end else if (done) begin
      while (q.size() > 0) begin
        e = q.pop_front();
        n_cmp  = n_cmp + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s: got no change, required %b at cycle %0d", e.name, e.vec, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
    end
  end

  // Stimulus.
  initial begin
    rst = 1'b1; act = 4'b0; lp_en = 1'b1; qacc = 1'b0; qdeny = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    mon_en = 1'b1;
    expect_at(-1, 5'b00000, "reset_state");

    // T1: idle in STOPPED for 20 cycles, no output change allowed.
    repeat (20) tick();

    // T2: single activity pulse wakes the DMA.
    act = 4'b0001;
    expect_at(1, 5'b01000, "t2_clk_en");
    expect_at(2, 5'b11000, "t2_qreqn");
    tick(); act = 4'b0;
    tick();
    qacc = 1'b1;
    expect_at(1, 5'b11100, "t2_ready");
    tick();

    // T3: activity at idle count 15 restarts the count; then full drop.
    repeat (15) tick();
    act = 4'b0100;
    expect_at(17, 5'b01000, "t3_req_after_restart");
    tick(); act = 4'b0;
    repeat (16) tick();
    qacc = 1'b0;
    expect_at(1, 5'b00000, "t3_stopped");
    repeat (4) tick();

    // T4: denial, continue, retry after another full idle period.
    act = 4'b0010;
    expect_at(1, 5'b01000, "t4_clk_en");
    expect_at(2, 5'b11000, "t4_qreqn");
    tick(); act = 4'b0;
    tick();
    qacc = 1'b1;
    expect_at(1, 5'b11100, "t4_ready");
    tick();
    expect_at(16, 5'b01000, "t4_req");
    repeat (16) tick();
    qdeny = 1'b1;
    expect_at(1, 5'b01010, "t4_deny_pulse");
    expect_at(2, 5'b11000, "t4_continue");
    repeat (2) tick();
    qdeny = 1'b0;
    expect_at(1, 5'b11100, "t4_retry_run");
    tick();
    expect_at(16, 5'b01000, "t4_retry_req");
    repeat (16) tick();

    // T5: activity during REQ is held and honoured after STOPPED.
    act = 4'b1000;
    tick(); act = 4'b0;
    qacc = 1'b0;
    expect_at(1, 5'b00000, "t5_stopped");
    expect_at(2, 5'b01000, "t5_pend_wake");
    expect_at(3, 5'b11000, "t5_pend_exit");
    repeat (3) tick();
    qacc = 1'b1;
    expect_at(1, 5'b11100, "t5_ready");
    tick();
    expect_at(16, 5'b01000, "t6_req");
    repeat (16) tick();

    // T6: simultaneous accept and deny -> sticky error; reset in EXIT.
    qacc = 1'b0; qdeny = 1'b1;
    expect_at(1, 5'b00001, "t6_err_set");
    tick(); qdeny = 1'b0;
    repeat (5) tick();
    act = 4'b0001;
    expect_at(1, 5'b01001, "t6_err_sticky_wake");
    expect_at(2, 5'b11001, "t6_err_sticky_exit");
    tick(); act = 4'b0;
    tick();
    rst = 1'b1;
    expect_at(1, 5'b00000, "t6_rst_in_exit");
    tick(); rst = 1'b0;
    tick();

    // T7: protocol errors while STOPPED.
    qdeny = 1'b1;
    expect_at(1, 5'b00001, "t7_deny_in_stopped");
    tick(); qdeny = 1'b0;
    tick();
    rst = 1'b1;
    expect_at(1, 5'b00000, "t7_rst_clear");
    tick(); rst = 1'b0;
    qacc = 1'b1;
    expect_at(1, 5'b00001, "t7_qacc_in_stopped");
    tick(); qacc = 1'b0;
    tick();
    rst = 1'b1;
    expect_at(1, 5'b00000, "t7_rst_clear2");
    tick(); rst = 1'b0;

    // T8: lp_en low forces RUN; lp_en low during REQ acts as wake after.
    lp_en = 1'b0;
    expect_at(1, 5'b01000, "t8_lp_wake0");
    expect_at(2, 5'b11000, "t8_lp_exit0");
    repeat (2) tick();
    qacc = 1'b1;
    expect_at(1, 5'b11100, "t8_ready");
    tick();
    repeat (30) tick();
    lp_en = 1'b1;
    expect_at(16, 5'b01000, "t8_req_after_lp_en");
    repeat (16) tick();
    lp_en = 1'b0;
    tick();
    qacc = 1'b0;
    expect_at(1, 5'b00000, "t8_stopped");
    expect_at(2, 5'b01000, "t8_lp_wake");
    expect_at(3, 5'b11000, "t8_lp_exit");
    repeat (6) tick();
    done = 1'b1;
  end

  // Absolute time limit.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
